// File: rtl/mux2_arbiter_pkg.sv
// mux2_arbiter_pkg
// Shared types and helpers for the two-requester mux arbiter.
//   arb_state_t     : arbiter FSM states (idle, owned by requester 0, owned by requester 1)
//   burst_cnt_width : bit width needed to count 0..max_burst without wrapping
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

    function automatic int unsigned burst_cnt_width(input int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mux2_arbiter_mux2.sv
// mux2
// Single-bit 2:1 multiplexer, the datapath cell replicated by mux2_arbiter.
// Ports:
//   d0  : in  data selected when sel = 0
//   d1  : in  data selected when sel = 1
//   sel : in  select
//   z   : out selected data
module mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic z
);

    assign z = sel ? d1 : d0;

endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter
// Shares one WIDTH-bit 2:1 mux between two requesters using round-robin arbitration
// with bounded bursts: the owner keeps the mux for up to MAX_BURST accepted transfers,
// then yields if the other side is waiting. Downstream sees a valid/ready port.
// Ports:
//   clk       : in  rising-edge clock
//   reset     : in  synchronous active-high reset
//   req0/d0   : in  requester 0 request and data
//   req1/d1   : in  requester 1 request and data
//   out_ready : in  downstream accepts data this cycle
//   out_valid : out out_data is valid
//   out_data  : out muxed data
//   sel       : out registered mux select (0 = d0, 1 = d1)
//   grant     : out one-hot owner, 2'b00 when idle
//   ack0/ack1 : out transfer accepted for requester 0/1 this cycle
module mux2_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             sel,
    output logic [1:0]       grant,
    output logic             ack0,
    output logic             ack1
);

    import mux2_arbiter_pkg::*;

    localparam int unsigned     CntW    = burst_cnt_width(MAX_BURST);
    // Count value at which the next transfer completes a full burst.
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);

    arb_state_t      r_state;
    arb_state_t      w_state_d;
    logic            r_sel;
    logic            w_sel_d;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic            r_last;
    logic            w_last_d;

    logic            w_own;
    logic            w_granted;
    logic            w_req_own;
    logic            w_req_oth;
    logic            w_valid;
    logic            w_xfer;
    logic [WIDTH-1:0] w_mux;

    always_comb begin
        w_state_d = r_state;
        w_sel_d   = r_sel;
        w_cnt_d   = r_cnt;
        w_last_d  = r_last;

        // w_own is the index of the current owner; only meaningful while granted.
        w_own     = (r_state == ARB_GRANT1);
        w_granted = (r_state != ARB_IDLE);
        w_req_own = w_own ? req1 : req0;
        w_req_oth = w_own ? req0 : req1;
        // Gated by reset so no transfer is offered or acknowledged in a reset cycle.
        w_valid   = w_granted & w_req_own & ~reset;
        w_xfer    = w_valid & out_ready;

        unique case (r_state)
            ARB_IDLE: begin
                w_cnt_d = '0;
                // On a tie, r_last = 1 means requester 1 was served last, so 0 wins.
                if (req0 && (!req1 || r_last)) begin
                    w_state_d = ARB_GRANT0;
                    w_sel_d   = 1'b0;
                end else if (req1) begin
                    w_state_d = ARB_GRANT1;
                    w_sel_d   = 1'b1;
                end
            end
            ARB_GRANT0, ARB_GRANT1: begin
                if (!w_req_own) begin
                    w_cnt_d = '0;
                    if (w_req_oth) begin
                        w_state_d = w_own ? ARB_GRANT0 : ARB_GRANT1;
                        w_sel_d   = ~w_own;
                    end else begin
                        w_state_d = ARB_IDLE;
                    end
                end else if (w_xfer) begin
                    w_last_d = w_own;
                    if (r_cnt == CntLast) begin
                        // Burst complete: hand over if contended, else restart the burst.
                        w_cnt_d = '0;
                        if (w_req_oth) begin
                            w_state_d = w_own ? ARB_GRANT0 : ARB_GRANT1;
                            w_sel_d   = ~w_own;
                        end
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = ARB_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_sel   <= 1'b0;
            r_cnt   <= '0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_sel   <= w_sel_d;
            r_cnt   <= w_cnt_d;
            r_last  <= w_last_d;
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_mux
        mux2 u_mux2 (
            .d0  (d0[i]),
            .d1  (d1[i]),
            .sel (r_sel),
            .z   (w_mux[i])
        );
    end

    assign out_valid = w_valid;
    assign out_data  = w_mux;
    assign sel       = r_sel;
    assign grant     = {r_state == ARB_GRANT1, r_state == ARB_GRANT0};
    assign ack0      = w_xfer & ~w_own;
    assign ack1      = w_xfer & w_own;

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter
// Directed, table-driven bench for mux2_arbiter (MAX_BURST = 4) plus a hand-written
// alternation sequence for a second instance with MAX_BURST = 1.
module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0;
    logic       req1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       out_ready;

    logic       out_valid;
    logic [7:0] out_data;
    logic       sel;
    logic [1:0] grant;
    logic       ack0;
    logic       ack1;

    logic       m1_valid;
    logic [7:0] m1_data;
    logic       m1_sel;
    logic [1:0] m1_grant;
    logic       m1_ack0;
    logic       m1_ack1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux2_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .d0        (d0),
        .req1      (req1),
        .d1        (d1),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .grant     (grant),
        .ack0      (ack0),
        .ack1      (ack1)
    );

    mux2_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut_mb1 (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .d0        (d0),
        .req1      (req1),
        .d1        (d1),
        .out_ready (out_ready),
        .out_valid (m1_valid),
        .out_data  (m1_data),
        .sel       (m1_sel),
        .grant     (m1_grant),
        .ack0      (m1_ack0),
        .ack1      (m1_ack1)
    );

    typedef struct {
        logic       rst;
        logic       r0;
        logic       r1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic       v;
        logic [7:0] data;
        logic       sel;
        logic [1:0] g;
        logic       a0;
        logic       a1;
        logic       xsel;   // sel/data unspecified (idle after a release)
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic r0, input logic r1,
                                input logic [7:0] vd0, input logic [7:0] vd1, input logic rdy,
                                input logic v, input logic [7:0] data, input logic vsel,
                                input logic [1:0] g, input logic a0, input logic a1,
                                input logic xsel);
        vec_t e;
        e.rst = rst; e.r0 = r0; e.r1 = r1; e.d0 = vd0; e.d1 = vd1; e.rdy = rdy;
        e.v = v; e.data = data; e.sel = vsel; e.g = g; e.a0 = a0; e.a1 = a1; e.xsel = xsel;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Row format: rst r0 r1 d0 d1 rdy | valid data sel grant ack0 ack1 xsel
        // Single requester: grant after 1 cycle, then no bubble across burst boundary.
        add(0, 1, 0, 8'hA5, 8'h3C, 1,  0, 8'hA5, 0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 1, 0, 8'hA5, 8'h3C, 1,  1, 8'hA5, 0, 2'b01, 1, 0, 0);
        // After 6 transfers (count 2) req0 drops with req1 waiting: direct switch.
        add(0, 0, 1, 8'hA5, 8'h3C, 1,  0, 8'hA5, 0, 2'b01, 0, 0, 0);
        // Contention: a fresh 4-burst for 1 proves the count was cleared, then 4 for 0.
        for (int i = 0; i < 4; i++) add(0, 1, 1, 8'hA5, 8'h3C, 1,  1, 8'h3C, 1, 2'b10, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 1, 8'hA5, 8'h3C, 1,  1, 8'hA5, 0, 2'b01, 1, 0, 0);
        // Backpressure in GRANT1 for 5 cycles, then 4 accepted before handing over.
        for (int i = 0; i < 5; i++) add(0, 1, 1, 8'hA5, 8'h3C, 0,  1, 8'h3C, 1, 2'b10, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 1, 8'hA5, 8'h3C, 1,  1, 8'h3C, 1, 2'b10, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 1, 8'hA5, 8'h3C, 1,  1, 8'hA5, 0, 2'b01, 1, 0, 0);
        add(0, 1, 1, 8'hA5, 8'h3C, 1,  1, 8'h3C, 1, 2'b10, 0, 1, 0);
        // Reset mid-burst in GRANT1: no ack, no valid in the reset cycle.
        add(1, 1, 1, 8'hA5, 8'h3C, 1,  0, 8'h3C, 1, 2'b10, 0, 0, 0);
        add(0, 1, 1, 8'hA5, 8'h3C, 1,  0, 8'hA5, 0, 2'b00, 0, 0, 0);
        add(0, 1, 1, 8'hA5, 8'h3C, 1,  1, 8'hA5, 0, 2'b01, 1, 0, 0);
        // Release to idle; tie from idle now goes to requester 1 (0 served last).
        add(0, 0, 0, 8'hA5, 8'h3C, 1,  0, 8'hA5, 0, 2'b01, 0, 0, 0);
        add(0, 1, 1, 8'hA5, 8'h3C, 1,  0, 8'h00, 0, 2'b00, 0, 0, 1);
        add(0, 1, 1, 8'hA5, 8'h5A, 1,  1, 8'h5A, 1, 2'b10, 0, 1, 0);
        add(0, 0, 0, 8'hA5, 8'h5A, 1,  0, 8'h5A, 1, 2'b10, 0, 0, 0);
        // Only req1 from idle.
        add(0, 0, 1, 8'h11, 8'hC3, 1,  0, 8'h00, 0, 2'b00, 0, 0, 1);
        add(0, 0, 1, 8'h11, 8'hC3, 1,  1, 8'hC3, 1, 2'b10, 0, 1, 0);

        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = 8'hA5; d1 = 8'h3C; out_ready = 1'b0;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            reset = tbl[i].rst; req0 = tbl[i].r0; req1 = tbl[i].r1;
            d0 = tbl[i].d0; d1 = tbl[i].d1; out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].v));
            chk($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("row%0d ack0", i), 32'(ack0), 32'(tbl[i].a0));
            chk($sformatf("row%0d ack1", i), 32'(ack1), 32'(tbl[i].a1));
            if (!tbl[i].xsel) begin
                chk($sformatf("row%0d sel", i), 32'(sel), 32'(tbl[i].sel));
                chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].data));
            end
        end

        // MAX_BURST = 1: strict alternation, switching only after each accepted transfer.
        @(negedge clk);
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
        d0 = 8'h11; d1 = 8'hC3;
        @(negedge clk);
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b0;
        #1;
        chk("mb1 idle grant", 32'(m1_grant), 32'(2'b00));
        chk("mb1 idle valid", 32'(m1_valid), 32'(1'b0));
        for (int i = 1; i <= 12; i++) begin
            logic [1:0] eg;
            logic       rdy;
            @(negedge clk);
            rdy = logic'(i % 2);
            out_ready = rdy;
            #1;
            eg = ((i / 2) % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("mb1 c%0d grant", i), 32'(m1_grant), 32'(eg));
            chk($sformatf("mb1 c%0d valid", i), 32'(m1_valid), 32'(1'b1));
            chk($sformatf("mb1 c%0d data", i), 32'(m1_data), 32'(eg[0] ? 8'h11 : 8'hC3));
            chk($sformatf("mb1 c%0d ack0", i), 32'(m1_ack0), 32'(rdy & eg[0]));
            chk($sformatf("mb1 c%0d ack1", i), 32'(m1_ack1), 32'(rdy & eg[1]));
            chk($sformatf("mb1 c%0d ack overlap", i), 32'(m1_ack0 & m1_ack1), 32'(1'b0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Shares one WIDTH-bit 2:1 mux datapath between two requesters; drives the mux select and a valid/ready output port.
- Round-robin arbitration with bounded bursts: a granted requester keeps the mux for up to MAX_BURST accepted transfers, then yields if the other side is waiting.
- Sits between two producer blocks and a single downstream consumer.

Parameters:
- WIDTH, 8, data width of each requester and of the output.
- MAX_BURST, 4, maximum consecutive accepted transfers per grant when contended; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 wants the datapath.
- d0  in  WIDTH  requester 0 data.
- req1  in  1  requester 1 wants the datapath.
- d1  in  WIDTH  requester 1 data.
- out_ready  in  1  downstream accepts data this cycle.
- out_valid  out  1  out_data is valid.
- out_data  out  WIDTH  muxed data.
- sel  out  1  mux select (0 = d0, 1 = d1); registered.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- ack0  out  1  requester 0 transfer accepted this cycle.
- ack1  out  1  requester 1 transfer accepted this cycle.

Behaviour:
- Reset: synchronous, active-high, wins over all other events.
  - Next edge: state IDLE, grant = 00, sel = 0, burst count = 0, last-served = 1 (so requester 0 has priority first).
  - Combinational outputs follow that state: out_valid = 0, ack0 = ack1 = 0.
  - Reset asserted mid-burst aborts the burst; no ack is issued in the reset cycle.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - Only req0 high -> GRANT0.
  - Only req1 high -> GRANT1.
  - Both high -> grant the requester not equal to last-served.
  - Neither high -> stay in IDLE.
  - sel is loaded on the same edge as the state.
  - Latency: request to grant is 1 cycle.
- GRANTk:
  - out_valid = req_k; out_data = mux(d0, d1, sel), combinational from the registered sel.
  - Transfer = out_valid & out_ready. ack_k = transfer. The non-granted ack is always 0.
  - On each transfer: burst count += 1 and last-served = k.
- Release evaluation, once per cycle in GRANTk:
  - (a) req_k low: release. Other request high -> GRANTother; otherwise -> IDLE. Count cleared.
  - (b) Transfer with count+1 == MAX_BURST: other request high -> GRANTother; otherwise stay in GRANTk with count cleared (no idle bubble).
  - (c) Otherwise stay in GRANTk.
- A direct GRANTk -> GRANTother switch is one edge: sel and grant update together; there is no IDLE cycle.
- Requester rules:
  - Hold data stable while req is high and no ack.
  - Dropping req without ack is legal and forfeits the grant.
  - Data is consumed only on the ack cycle.
- Backpressure: out_ready low holds the state and count; ack stays 0.
- Counter: width $clog2(MAX_BURST+1), never wraps. MAX_BURST = 1 gives strict alternation under contention.
- Invariants:
  - grant is one-hot or zero.
  - sel == grant[1] whenever grant != 00.
  - ack0 & ack1 is never 1.

Decomposition:
- Package mux2_arbiter_pkg holds:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_GRANT0, ARB_GRANT1};
  - function burst_cnt_width(max_burst).
- Sub-module: the existing 1-bit mux2 (d0, d1, sel, z), instantiated WIDTH times in a generate loop for the datapath.
- FSM, counter and last-served register live in mux2_arbiter.

Test Plan:
- Reset then req0 = 1, d0 = 8'hA5, out_ready = 1 -> cycle 1: grant = 01, sel = 0, out_valid = 1, out_data = A5, ack0 = 1 every cycle. With req1 low, no IDLE bubble after the 4th transfer.
- req0 = req1 = 1 from reset, out_ready = 1, MAX_BURST = 4 -> order: 4 acks to req0, then 4 to req1, repeating. Switch cycles show grant 01 -> 10 with no idle cycle.
- GRANT1 with out_ready = 0 for 5 cycles -> out_valid = 1, out_data = d1, ack1 = 0, count frozen. Raising out_ready gives ack1 on that cycle.
- GRANT0 after 2 transfers, req0 drops, req1 = 1 -> next cycle grant = 10, sel = 1, count = 0.
- Reset asserted in GRANT1 mid-burst with req0 = req1 = 1 -> next edge: IDLE, grant = 00, out_valid = 0. Release reset: grant goes to requester 0 first.
- MAX_BURST = 1, both requesting, out_ready toggling 1/0 -> grant alternates only after each accepted transfer. ack0 and ack1 are never simultaneous.
